// File: rtl/phy_reg_file_pkg.sv
// Shared sizing and types for the physical register file.
// Latency: n/a (package). Backpressure: n/a.
// Optional same-cycle writeback forwarding is enabled by PHY_REGFILE_WB_BYPASS_EN.
package phy_reg_file_pkg;

    localparam int PHY_REG_NUM      = 64;
    localparam int ARCH_REG_NUM     = 32;
    localparam int PHY_REG_ID_WIDTH = 6;
    localparam int REG_DATA_WIDTH   = 32;
    localparam int READREG_WIDTH    = 2;
    localparam int WB_WIDTH         = 4;
    localparam int COMMIT_WIDTH     = 4;

    typedef logic [PHY_REG_ID_WIDTH-1:0] phy_reg_id_t;
    typedef logic [REG_DATA_WIDTH-1:0]   reg_data_t;

endpackage

// File: rtl/phy_regfile_read_port.sv
// One combinational read port: id -> stored data/valid, optional writeback forwarding.
// Latency: 0 cycles. Backpressure: none, always serves.
// With PHY_REGFILE_WB_BYPASS_EN, a same-cycle writeback to the id overrides storage unless killed.
module phy_regfile_read_port
    import phy_reg_file_pkg::*;
#(
    parameter int NUM  = PHY_REG_NUM,
    parameter int IDW  = PHY_REG_ID_WIDTH,
    parameter int DW   = REG_DATA_WIDTH,
    parameter int WBN  = WB_WIDTH
) (
    input  logic [IDW-1:0] id,
    input  logic [DW-1:0]  regs [NUM],
    input  logic [NUM-1:0] valid,
    output logic [DW-1:0]  data,
    output logic           data_valid
`ifdef PHY_REGFILE_WB_BYPASS_EN
    ,
    input  logic [IDW-1:0] wb_id   [WBN],
    input  logic [DW-1:0]  wb_data [WBN],
    input  logic [WBN-1:0] wb_we,
    input  logic [NUM-1:0] kill
`endif
);

    always_comb begin
        data       = regs[id];
        data_valid = valid[id];
`ifdef PHY_REGFILE_WB_BYPASS_EN
        // Ascending scan so the highest matching writeback port wins.
        if (!kill[id]) begin
            for (int w = 0; w < WBN; w++) begin
                if (wb_we[w] && (wb_id[w] == id)) begin
                    data       = wb_data[w];
                    data_valid = 1'b1;
                end
            end
        end
`endif
    end

endmodule

// File: rtl/phy_reg_file.sv
// Physical register file: data words plus per-entry ready bits, written by writeback, cleared/restored by commit.
// Latency: reads 0 cycles, updates visible after the next clk edge. Backpressure: none.
// PHY_REGFILE_WB_BYPASS_EN enables same-cycle writeback forwarding on every read port.
module phy_reg_file #(
    parameter int PHY_REG_NUM      = phy_reg_file_pkg::PHY_REG_NUM,
    parameter int ARCH_REG_NUM     = phy_reg_file_pkg::ARCH_REG_NUM,
    parameter int PHY_REG_ID_WIDTH = phy_reg_file_pkg::PHY_REG_ID_WIDTH,
    parameter int REG_DATA_WIDTH   = phy_reg_file_pkg::REG_DATA_WIDTH,
    parameter int READREG_WIDTH    = phy_reg_file_pkg::READREG_WIDTH,
    parameter int WB_WIDTH         = phy_reg_file_pkg::WB_WIDTH,
    parameter int COMMIT_WIDTH     = phy_reg_file_pkg::COMMIT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PHY_REG_ID_WIDTH-1:0] readreg_phyf_id         [READREG_WIDTH][2],
    output logic [REG_DATA_WIDTH-1:0]   phyf_readreg_data       [READREG_WIDTH][2],
    output logic                        phyf_readreg_data_valid [READREG_WIDTH][2],
    input  logic [PHY_REG_ID_WIDTH-1:0] issue_phyf_id           [READREG_WIDTH][2],
    output logic [REG_DATA_WIDTH-1:0]   phyf_issue_data         [READREG_WIDTH][2],
    output logic                        phyf_issue_data_valid   [READREG_WIDTH][2],
    input  logic [PHY_REG_ID_WIDTH-1:0] wb_phyf_id              [WB_WIDTH],
    input  logic [REG_DATA_WIDTH-1:0]   wb_phyf_data            [WB_WIDTH],
    input  logic [WB_WIDTH-1:0]         wb_phyf_we,
    input  logic [PHY_REG_ID_WIDTH-1:0] commit_phyf_id          [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0]     commit_phyf_invalid,
    input  logic [PHY_REG_ID_WIDTH-1:0] commit_phyf_flush_id,
    input  logic                        commit_phyf_flush_invalid,
    input  logic [PHY_REG_NUM-1:0]      commit_phyf_data_valid,
    input  logic                        commit_phyf_data_valid_restore
);

    localparam logic [PHY_REG_NUM-1:0] ONE       = 1;
    // Architectural ids 1..ARCH_REG_NUM-1 hold committed values at reset; entry 0 does not.
    localparam logic [PHY_REG_NUM-1:0] VALID_RST = ((ONE << ARCH_REG_NUM) - ONE) & ~ONE;

    logic [REG_DATA_WIDTH-1:0] data [PHY_REG_NUM];
    logic [PHY_REG_NUM-1:0]    valid;
    logic [PHY_REG_NUM-1:0]    valid_nxt;
    logic [PHY_REG_NUM-1:0]    kill;

    // Priority per entry: restore > invalidate > writeback set > hold.
    always_comb begin
        kill = '0;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (commit_phyf_invalid[c]) kill[commit_phyf_id[c]] = 1'b1;
        end
        if (commit_phyf_flush_invalid) kill[commit_phyf_flush_id] = 1'b1;

        valid_nxt = valid;
        for (int w = 0; w < WB_WIDTH; w++) begin
            if (wb_phyf_we[w]) valid_nxt[wb_phyf_id[w]] = 1'b1;
        end
        valid_nxt = valid_nxt & ~kill;
        if (commit_phyf_data_valid_restore) valid_nxt = commit_phyf_data_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= VALID_RST;
        end else begin
            valid <= valid_nxt;
        end
    end

    // Data is written even when the entry's valid update loses; last port in the loop wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHY_REG_NUM; i++) data[i] <= '0;
        end else begin
            for (int w = 0; w < WB_WIDTH; w++) begin
                if (wb_phyf_we[w]) data[wb_phyf_id[w]] <= wb_phyf_data[w];
            end
        end
    end

`ifdef PHY_REGFILE_WB_BYPASS_EN
    logic [PHY_REG_NUM-1:0] fwd_kill;
    assign fwd_kill = commit_phyf_data_valid_restore ? '1 : kill;
`endif

    for (genvar r = 0; r < READREG_WIDTH; r++) begin : g_lane
        for (genvar o = 0; o < 2; o++) begin : g_opnd
            phy_regfile_read_port #(
                .NUM (PHY_REG_NUM),
                .IDW (PHY_REG_ID_WIDTH),
                .DW  (REG_DATA_WIDTH),
                .WBN (WB_WIDTH)
            ) u_readreg (
                .id         (readreg_phyf_id[r][o]),
                .regs       (data),
                .valid      (valid),
                .data       (phyf_readreg_data[r][o]),
                .data_valid (phyf_readreg_data_valid[r][o])
`ifdef PHY_REGFILE_WB_BYPASS_EN
                ,
                .wb_id      (wb_phyf_id),
                .wb_data    (wb_phyf_data),
                .wb_we      (wb_phyf_we),
                .kill       (fwd_kill)
`endif
            );

            phy_regfile_read_port #(
                .NUM (PHY_REG_NUM),
                .IDW (PHY_REG_ID_WIDTH),
                .DW  (REG_DATA_WIDTH),
                .WBN (WB_WIDTH)
            ) u_issue (
                .id         (issue_phyf_id[r][o]),
                .regs       (data),
                .valid      (valid),
                .data       (phyf_issue_data[r][o]),
                .data_valid (phyf_issue_data_valid[r][o])
`ifdef PHY_REGFILE_WB_BYPASS_EN
                ,
                .wb_id      (wb_phyf_id),
                .wb_data    (wb_phyf_data),
                .wb_we      (wb_phyf_we),
                .kill       (fwd_kill)
`endif
            );
        end
    end

endmodule

// File: tb/tb_phy_reg_file.sv
// Self-checking bench for phy_reg_file against an entry-level reference model.
module tb_phy_reg_file;
    import phy_reg_file_pkg::*;

    localparam int N  = PHY_REG_NUM;
    localparam int RW = READREG_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    phy_reg_id_t rr_id   [RW][2];
    reg_data_t   rr_data [RW][2];
    logic        rr_vld  [RW][2];
    phy_reg_id_t is_id   [RW][2];
    reg_data_t   is_data [RW][2];
    logic        is_vld  [RW][2];

    phy_reg_id_t                wb_id   [WB_WIDTH];
    reg_data_t                  wb_data [WB_WIDTH];
    logic [WB_WIDTH-1:0]        wb_we;
    phy_reg_id_t                cm_id   [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]    cm_inv;
    phy_reg_id_t                fl_id;
    logic                       fl_inv;
    logic [N-1:0]               snap;
    logic                       restore;

    reg_data_t m_data  [N];
    logic      m_valid [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phy_reg_file dut (
        .clk                            (clk),
        .rst                            (rst),
        .readreg_phyf_id                (rr_id),
        .phyf_readreg_data              (rr_data),
        .phyf_readreg_data_valid        (rr_vld),
        .issue_phyf_id                  (is_id),
        .phyf_issue_data                (is_data),
        .phyf_issue_data_valid          (is_vld),
        .wb_phyf_id                     (wb_id),
        .wb_phyf_data                   (wb_data),
        .wb_phyf_we                     (wb_we),
        .commit_phyf_id                 (cm_id),
        .commit_phyf_invalid            (cm_inv),
        .commit_phyf_flush_id           (fl_id),
        .commit_phyf_flush_invalid      (fl_inv),
        .commit_phyf_data_valid         (snap),
        .commit_phyf_data_valid_restore (restore)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_data[i]  = '0;
            m_valid[i] = (i >= 1) && (i < ARCH_REG_NUM);
        end
    endtask

`ifdef PHY_REGFILE_WB_BYPASS_EN
    function automatic bit killed(input phy_reg_id_t id);
        if (restore) return 1'b1;
        if (fl_inv && fl_id == id) return 1'b1;
        for (int c = 0; c < COMMIT_WIDTH; c++)
            if (cm_inv[c] && cm_id[c] == id) return 1'b1;
        return 1'b0;
    endfunction
`endif

    task automatic exp_read(input phy_reg_id_t id, output reg_data_t d, output logic v);
        d = m_data[id];
        v = m_valid[id];
`ifdef PHY_REGFILE_WB_BYPASS_EN
        if (!killed(id))
            for (int w = 0; w < WB_WIDTH; w++)
                if (wb_we[w] && wb_id[w] == id) begin
                    d = wb_data[w];
                    v = 1'b1;
                end
`endif
    endtask

    task automatic check_reads(input string tag);
        reg_data_t d;
        logic v;
        for (int r = 0; r < RW; r++) begin
            for (int o = 0; o < 2; o++) begin
                exp_read(rr_id[r][o], d, v);
                chk($sformatf("%s rr%0d.%0d id%0d data", tag, r, o, rr_id[r][o]), rr_data[r][o], d);
                chk($sformatf("%s rr%0d.%0d id%0d valid", tag, r, o, rr_id[r][o]), 32'(rr_vld[r][o]), 32'(v));
                exp_read(is_id[r][o], d, v);
                chk($sformatf("%s is%0d.%0d id%0d data", tag, r, o, is_id[r][o]), is_data[r][o], d);
                chk($sformatf("%s is%0d.%0d id%0d valid", tag, r, o, is_id[r][o]), 32'(is_vld[r][o]), 32'(v));
            end
        end
    endtask

    // Each entry resolved independently: restore, else any invalidate, else any writeback, else hold.
    task automatic model_edge();
        reg_data_t nd [N];
        logic      nv [N];
        bit hit_inv, hit_wb;
        for (int i = 0; i < N; i++) begin
            nd[i]   = m_data[i];
            hit_inv = fl_inv && (int'(fl_id) == i);
            for (int c = 0; c < COMMIT_WIDTH; c++)
                if (cm_inv[c] && int'(cm_id[c]) == i) hit_inv = 1'b1;
            hit_wb = 1'b0;
            for (int w = 0; w < WB_WIDTH; w++)
                if (wb_we[w] && int'(wb_id[w]) == i) begin
                    hit_wb = 1'b1;
                    nd[i]  = wb_data[w];
                end
            nv[i] = restore ? snap[i] : hit_inv ? 1'b0 : hit_wb ? 1'b1 : m_valid[i];
        end
        for (int i = 0; i < N; i++) begin
            m_data[i]  = nd[i];
            m_valid[i] = nv[i];
        end
    endtask

    task automatic tick(input string tag);
        #1;
        check_reads(tag);
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_we   = '0;
        cm_inv  = '0;
        fl_inv  = 1'b0;
        restore = 1'b0;
        snap    = '0;
        for (int w = 0; w < WB_WIDTH; w++) begin
            wb_id[w]   = '0;
            wb_data[w] = '0;
        end
        for (int c = 0; c < COMMIT_WIDTH; c++) cm_id[c] = '0;
        fl_id = '0;
    endtask

    task automatic set_reads(input int base);
        for (int r = 0; r < RW; r++)
            for (int o = 0; o < 2; o++) begin
                rr_id[r][o] = phy_reg_id_t'((base + r * 2 + o) % N);
                is_id[r][o] = phy_reg_id_t'((base + RW * 2 + r * 2 + o) % N);
            end
    endtask

    task automatic sweep(input string tag);
        for (int id = 0; id < N; id++) begin
            set_reads(id);
            tick(tag);
        end
    endtask

    initial begin
        idle();
        set_reads(0);
        for (int r = 0; r < RW; r++)
            for (int o = 0; o < 2; o++) begin
                rr_id[r][o] = '0;
                is_id[r][o] = '0;
            end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reads("reset_id0");
        chk("reset_id0_const", 32'(rr_vld[0][0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        sweep("reset_sweep");
        set_reads(5);
        #1;
        chk("reset_id5_valid_const", 32'(rr_vld[0][0]), 32'd1);
        chk("reset_id9_data_const", is_data[0][0], 32'd0);
        set_reads(ARCH_REG_NUM);
        #1;
        chk("reset_arch_valid_const", 32'(rr_vld[0][0]), 32'd0);
        @(negedge clk);

        // Writeback port i writes id i
        for (int i = 0; i < WB_WIDTH; i++) begin
            idle();
            wb_we[i]   = 1'b1;
            wb_id[i]   = phy_reg_id_t'(i);
            wb_data[i] = 32'h1acdef89 + i;
            set_reads(i);
            tick("wb_write");
            idle();
            tick("wb_read");
            chk($sformatf("wb_const_data id%0d", i), rr_data[0][0], 32'h1acdef89 + i);
            chk($sformatf("wb_const_valid id%0d", i), 32'(rr_vld[0][0]), 32'd1);
        end

        // Commit port i invalidates id i
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            idle();
            cm_inv[i] = 1'b1;
            cm_id[i]  = phy_reg_id_t'(i);
            set_reads(0);
            tick("commit_inv");
        end
        idle();
        sweep("commit_sweep");

        // Flush id 10 held, then restore all-ones under the flush
        fl_inv = 1'b1;
        fl_id  = 6'd10;
        set_reads(10);
        tick("flush_set");
        tick("flush_hold");
        restore = 1'b1;
        snap    = '1;
        tick("restore_ones");
        restore = 1'b0;
        #1;
        chk("restore_win_const", 32'(rr_vld[0][0]), 32'd1);
        idle();
        tick("flush_release");
        sweep("after_restore");

        restore = 1'b1;
        snap    = '0;
        tick("restore_zero");
        idle();
        sweep("zero_sweep");
        restore = 1'b1;
        for (int i = 0; i < N; i++) snap[i] = (i >= 1) && (i < ARCH_REG_NUM);
        tick("restore_arch");
        idle();
        sweep("arch_sweep");

        // Same-cycle writeback and invalidate of id 5
        wb_we[0]   = 1'b1;
        wb_id[0]   = 6'd5;
        wb_data[0] = 32'hdeadbeef;
        cm_inv[1]  = 1'b1;
        cm_id[1]   = 6'd5;
        set_reads(5);
        tick("wb_inv_same");
        idle();
        tick("wb_inv_after");
        chk("wb_inv_const_valid", 32'(rr_vld[0][0]), 32'd0);
        chk("wb_inv_const_data", rr_data[0][0], 32'hdeadbeef);

        // Random traffic with a mid-run asynchronous reset
        for (int it = 0; it < 400; it++) begin
            idle();
            for (int w = 0; w < WB_WIDTH; w++) begin
                wb_we[w]   = ($urandom_range(0, 2) == 0);
                wb_id[w]   = phy_reg_id_t'($urandom_range(0, N - 1));
                wb_data[w] = $urandom;
            end
            for (int c = 0; c < COMMIT_WIDTH; c++) begin
                cm_inv[c] = ($urandom_range(0, 3) == 0);
                cm_id[c]  = phy_reg_id_t'($urandom_range(0, N - 1));
            end
            fl_inv  = ($urandom_range(0, 7) == 0);
            fl_id   = phy_reg_id_t'($urandom_range(0, N - 1));
            restore = ($urandom_range(0, 15) == 0);
            snap    = {$urandom, $urandom};
            for (int r = 0; r < RW; r++)
                for (int o = 0; o < 2; o++) begin
                    rr_id[r][o] = (wb_we[0] && $urandom_range(0, 1) == 0) ? wb_id[0]
                                : phy_reg_id_t'($urandom_range(0, N - 1));
                    is_id[r][o] = phy_reg_id_t'($urandom_range(0, N - 1));
                end
            if (it == 200) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_reads("async_reset");
                tick("reset_held");
                rst = 1'b0;
            end else begin
                tick("random");
            end
        end

        idle();
        sweep("final_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_reg_file.md
# phy_reg_file

Physical register file of the out-of-order core: holds `PHY_REG_NUM` data words plus a per-entry valid (data-ready) bit. Combinationally serves the readreg and issue stages, is written by the writeback stage, and has its valid bits cleared or bulk-restored by the commit stage (register free / flush recovery).

## Interface
Parameters (defaults; widths come from the shared config):
- PHY_REG_NUM, 64, number of physical registers
- ARCH_REG_NUM, 32, architectural registers; ids 1..ARCH_REG_NUM-1 start valid
- PHY_REG_ID_WIDTH, 6, log2(PHY_REG_NUM)
- REG_DATA_WIDTH, 32, data word width
- READREG_WIDTH, 2, readreg/issue lanes (2 operands each)
- WB_WIDTH, 4, writeback ports
- COMMIT_WIDTH, 4, commit invalidate ports

Ports (one clock; reset is asynchronous and active-high; clock `clk`, reset `rst`):
- clk  in  1  clock
- rst  in  1  async active-high reset
- readreg_phyf_id  in  [READREG_WIDTH][2] x ID  readreg source ids
- phyf_readreg_data  out  [READREG_WIDTH][2] x DATA  readreg data
- phyf_readreg_data_valid  out  [READREG_WIDTH][2] x 1  readreg valid
- issue_phyf_id / phyf_issue_data / phyf_issue_data_valid  same shapes, issue stage
- wb_phyf_id  in  [WB_WIDTH] x ID  writeback target
- wb_phyf_data  in  [WB_WIDTH] x DATA  writeback data
- wb_phyf_we  in  WB_WIDTH  per-port write enable
- commit_phyf_id  in  [COMMIT_WIDTH] x ID  ids to invalidate
- commit_phyf_invalid  in  COMMIT_WIDTH  per-port invalidate enable
- commit_phyf_flush_id  in  ID  flush invalidate id
- commit_phyf_flush_invalid  in  1  flush invalidate enable
- commit_phyf_data_valid  in  PHY_REG_NUM  valid snapshot for restore
- commit_phyf_data_valid_restore  in  1  load snapshot into valid vector

## Operation
- State: data[PHY_REG_NUM], valid[PHY_REG_NUM].
- Reset: all data = 0; valid[i] = 1 for 1 <= i < ARCH_REG_NUM, else 0 (entry 0 invalid, not hardwired).
- Reads: all 8 read ports purely combinational: data = data[id], valid = valid[id]. Independent, no ordering between ports.
- Writeback: per port with we=1: data[id] <= wb data, valid[id] <= 1. Any id including 0 is writable. Same id on multiple ports: highest port index wins.
- Invalidate: per commit port with invalid=1, and flush port with flush_invalid=1: valid[id] <= 0. Data untouched.
- Restore: valid <= commit_phyf_data_valid (full vector, including bit 0). Data untouched.
- Per-entry valid priority each cycle: restore > invalidate (commit/flush) > writeback set > hold. Writeback data is still written when its valid update loses.
- Ids >= PHY_REG_NUM do not occur; behaviour undefined.

## Timing
- Read latency 0 (combinational from current state); all updates take effect at next rising clk edge.
- No write-to-read forwarding by default: a read in the writeback cycle returns the pre-edge value.
- rst asserted mid-operation immediately forces reset state; inputs ignored while rst=1.

## Configuration
- PHY_REGFILE_WB_BYPASS_EN: when defined, each read port forwards same-cycle writeback data (valid=1) on id match (highest matching wb port wins), overriding stored state unless the same id is being restored/invalidated (stored-state rules then apply next cycle only). Undefined (default): no forwarding, reads reflect register state only.

## Structure
- Shared package: PHY_REG_NUM, ARCH_REG_NUM, widths, typedefs phy_reg_id_t and reg_data_t.
- One sub-module natural: phy_regfile_read_port (id -> data/valid mux, optional bypass), instantiated 2*READREG_WIDTH*2 times.

## Test plan
- Reset, all ids 0 -> every valid output 0; then sweep each read port over ids 1..ARCH_REG_NUM-1 -> valid 1, data 0, other ports valid 0; ids ARCH_REG_NUM..PHY_REG_NUM-1 -> valid 0.
- Writeback port i writes id i with 0x1acdef89+i, one per cycle -> next cycle read id i: valid 1, data 0x1acdef89+i (id 0 included).
- Commit port i invalidates id i, one per cycle -> ids 0..i valid 0, i+1..ARCH_REG_NUM-1 valid 1, higher ids valid 0.
- Flush invalidate id 10 (kept asserted) -> id 10 valid 0; restore all-ones while flush still asserted -> every id valid 1 (restore wins).
- Restore all-zeros -> every id valid 0; restore bits 1..ARCH_REG_NUM-1 -> id 0 invalid, 1..ARCH_REG_NUM-1 valid, rest invalid.
- Same-cycle writeback and commit invalidate of id 5 -> next cycle valid 0, data updated; without bypass macro, same-cycle read of id 5 shows old data.
